// File: rtl/branch_pkg.sv
// Shared types for branch resolution: tracked entry, FSM state.
// Opcode constants identify the branches fetch pushes.
package branch_pkg;

  localparam int PC_W = 14;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef logic [PC_W-1:0] pc_t;

  typedef struct packed {
    pc_t  pc;
    logic ptaken;
  } br_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

endpackage

// File: rtl/br_track_fifo.sv
// In-order circular queue of predicted branches awaiting resolve.
// Clear wins over push/pop so a mispredict drops wrong-path entries.
module br_track_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  br_entry_t     push_data,
  input  logic          pop,
  output br_entry_t     pop_data,
  output logic [CW-1:0] count
);

  br_entry_t     mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign pop_data = mem[rptr];

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= push_data;
  end

  // Pointers and occupancy; pointers wrap because DEPTH is 2^AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves predicted branches in order: predictor updates,
// mispredict flush/redirect and performance counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int PC_W  = 14,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_taken,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             err_underflow
);

  localparam int CW = $clog2(DEPTH + 1);

  br_state_e     state;
  br_entry_t     head;
  br_entry_t     new_ent;
  logic [CW-1:0] count;
  logic          empty;
  logic          pop;
  logic          mispred;
  logic          push;

  assign empty   = (count == '0);
  assign pred_ready = rst_n && (state == RUN)
                   && (count < CW'(DEPTH));
  assign pop     = res_valid && !empty;
  assign mispred = pop && (head.ptaken != res_taken);
  assign push    = pred_valid && pred_ready && !mispred;
  assign new_ent = '{pc: pred_pc, ptaken: pred_taken};

  br_track_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (mispred),
    .push      (push),
    .push_data (new_ent),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  // One-cycle refill bubble after every mispredict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN:     state <= mispred ? FLUSH : RUN;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Update stream and redirect; data fields hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_valid <= pop;
      flush     <= mispred;
      if (pop) begin
        upd_pc    <= head.pc;
        upd_taken <= res_taken;
      end
      if (mispred) begin
        redirect_pc <= res_taken ? res_target
                                 : head.pc + PC_W'(1);
      end
    end
  end

  // Saturating counters and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt    <= '0;
      mispred_cnt   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (pop && branch_cnt != '1)
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispred && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      if (res_valid && empty)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve.
// Hand-computed vectors for updates, flushes and counters.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_valid;
  logic [13:0] pred_pc;
  logic        pred_taken;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic [13:0] res_target;
  logic        upd_valid;
  logic [13:0] upd_pc;
  logic        upd_taken;
  logic        flush;
  logic [13:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;
  logic        err_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_ready    (pred_ready),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_target    (res_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt),
    .err_underflow (err_underflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [13:0] pc,
                       input logic pt, input logic rv,
                       input logic rt, input logic [13:0] tg);
    pred_valid = pv;
    pred_pc    = pc;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    res_target = tg;
  endtask

  task automatic push(input logic [13:0] pc, input logic pt);
    drive(1'b1, pc, pt, 1'b0, 1'b0, 14'h0);
    step();
  endtask

  task automatic resolve(input logic rt, input logic [13:0] tg);
    drive(1'b0, 14'h0, 1'b0, 1'b1, rt, tg);
    step();
  endtask

  task automatic idle();
    drive(1'b0, 14'h0, 1'b0, 1'b0, 1'b0, 14'h0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 14'h0, 1'b0, 1'b0, 1'b0, 14'h0);
    #3;
    chk("rst_ready", pred_ready, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_bcnt", branch_cnt, 0);
    chk("rst_mcnt", mispred_cnt, 0);
    chk("rst_err", err_underflow, 0);
    #10;
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", pred_ready, 1);

    // correct prediction
    push(14'h010, 1'b1);
    resolve(1'b1, 14'h020);
    chk("ok_upd_valid", upd_valid, 1);
    chk("ok_upd_pc", upd_pc, 14'h010);
    chk("ok_upd_taken", upd_taken, 1);
    chk("ok_flush", flush, 0);
    chk("ok_bcnt", branch_cnt, 1);
    chk("ok_mcnt", mispred_cnt, 0);

    // not-taken mispredict
    push(14'h100, 1'b1);
    push(14'h104, 1'b0);
    resolve(1'b0, 14'h200);
    chk("nt_flush", flush, 1);
    chk("nt_redirect", redirect_pc, 14'h101);
    chk("nt_upd_pc", upd_pc, 14'h100);
    chk("nt_upd_taken", upd_taken, 0);
    chk("nt_mcnt", mispred_cnt, 1);
    chk("nt_bcnt", branch_cnt, 2);
    chk("nt_count", 32'(dut.u_fifo.count), 0);
    chk("nt_ready_bubble", pred_ready, 0);
    idle();
    chk("nt_flush_drop", flush, 0);
    chk("nt_upd_idle", upd_valid, 0);
    chk("nt_ready_back", pred_ready, 1);
    chk("nt_redirect_hold", redirect_pc, 14'h101);

    // taken mispredict, then not-taken wrap
    push(14'h3FFF, 1'b0);
    resolve(1'b1, 14'h0040);
    chk("tk_flush", flush, 1);
    chk("tk_redirect", redirect_pc, 14'h0040);
    chk("tk_mcnt", mispred_cnt, 2);
    idle();
    push(14'h3FFF, 1'b1);
    resolve(1'b0, 14'h1234);
    chk("wrap_redirect", redirect_pc, 14'h0000);
    chk("wrap_mcnt", mispred_cnt, 3);
    chk("wrap_bcnt", branch_cnt, 4);
    idle();

    // full queue and concurrency
    push(14'h011, 1'b1);
    push(14'h012, 1'b1);
    push(14'h013, 1'b1);
    push(14'h014, 1'b1);
    chk("full_ready", pred_ready, 0);
    drive(1'b1, 14'h055, 1'b1, 1'b1, 1'b1, 14'h0);
    step();
    chk("full_pop_pc", upd_pc, 14'h011);
    chk("full_count", 32'(dut.u_fifo.count), 3);
    chk("full_ready_back", pred_ready, 1);
    drive(1'b1, 14'h015, 1'b1, 1'b1, 1'b1, 14'h0);
    step();
    chk("pp_pc", upd_pc, 14'h012);
    chk("pp_count", 32'(dut.u_fifo.count), 3);
    resolve(1'b1, 14'h0);
    chk("drain0", upd_pc, 14'h013);
    resolve(1'b1, 14'h0);
    chk("drain1", upd_pc, 14'h014);
    resolve(1'b1, 14'h0);
    chk("drain2", upd_pc, 14'h015);
    chk("drain_flush", flush, 0);
    chk("drain_bcnt", branch_cnt, 9);
    idle();

    // mispredict with simultaneous push
    push(14'h020, 1'b1);
    push(14'h021, 1'b1);
    drive(1'b1, 14'h022, 1'b1, 1'b1, 1'b0, 14'h0);
    step();
    chk("mp_flush", flush, 1);
    chk("mp_upd_pc", upd_pc, 14'h020);
    chk("mp_redirect", redirect_pc, 14'h021);
    chk("mp_count", 32'(dut.u_fifo.count), 0);
    chk("mp_mcnt", mispred_cnt, 4);
    idle();

    // underflow: proves the dropped push left no entry
    chk("uf_ready", pred_ready, 1);
    resolve(1'b1, 14'h0);
    chk("uf_err", err_underflow, 1);
    chk("uf_upd_valid", upd_valid, 0);
    chk("uf_bcnt", branch_cnt, 10);
    idle();
    chk("uf_sticky", err_underflow, 1);

    // async reset mid-stream
    push(14'h030, 1'b1);
    push(14'h031, 1'b0);
    push(14'h032, 1'b1);
    drive(1'b0, 14'h0, 1'b0, 1'b0, 1'b0, 14'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ready", pred_ready, 0);
    chk("ar_upd_pc", upd_pc, 0);
    chk("ar_redirect", redirect_pc, 0);
    chk("ar_bcnt", branch_cnt, 0);
    chk("ar_mcnt", mispred_cnt, 0);
    chk("ar_err", err_underflow, 0);
    chk("ar_count", 32'(dut.u_fifo.count), 0);
    #10;
    rst_n = 1'b1;
    step();
    chk("ar_ready_back", pred_ready, 1);
    chk("ar_count_back", 32'(dut.u_fifo.count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Resolve-side counterpart of the 2-bit-counter branch predictor.
- Fetch pushes each predicted branch (pc and predicted direction) into an in-order tracking queue. Execute pops the oldest entry with the actual outcome.
- The block emits the predictor update stream (upd_pc→beforepc, upd_taken→pcsrc), the mispredict flush/redirect to the PC mux, and performance counters.

Parameters:
- PC_W, 14, PC width; PC is word-addressed, so the fall-through address is pc+1.
- DEPTH, 4, tracking-queue entries; power of 2, minimum 2.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pred_valid  in  1  fetch issues a branch (op beq/bne) with a prediction.
- pred_pc  in  PC_W  PC of that branch.
- pred_taken  in  1  predicted direction (counter >= 2).
- pred_ready  out  1  queue can accept a push.
- res_valid  in  1  execute resolves the oldest in-flight branch.
- res_taken  in  1  actual direction.
- res_target  in  PC_W  actual taken target.
- upd_valid  out  1  predictor update strobe.
- upd_pc  out  PC_W  PC whose counter to update.
- upd_taken  out  1  actual outcome for the counter.
- flush  out  1  one-cycle mispredict pulse; kill younger instructions.
- redirect_pc  out  PC_W  correct next PC, valid when flush=1.
- branch_cnt  out  CNT_W  resolved branches.
- mispred_cnt  out  CNT_W  mispredicted branches.
- err_underflow  out  1  sticky: res_valid seen while queue empty.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: pred_ready=0, upd_valid=0, upd_pc=0, upd_taken=0, flush=0, redirect_pc=0, counters=0, err_underflow=0.
  - Internal: queue empty, read/write pointers 0, FSM=RUN.
  - Reset asserted mid-operation discards all entries immediately.
- Queue: circular buffer with pointers mod DEPTH and a count of 0..DEPTH.
  - pred_ready = (state==RUN) && (count<DEPTH), combinational from registered state.
  - A push happens when pred_valid && pred_ready. pred_valid while pred_ready=0 is ignored and is the fetch stage's responsibility.
  - When full, pred_ready=0 even if a pop happens in the same cycle. There is no full bypass.
  - Push and pop in the same cycle with 0<count<DEPTH: count is unchanged, both pointers advance.
- Resolve, on res_valid with count>0:
  - Pop the oldest entry {pc, ptaken}.
  - Registered outputs, 1-cycle latency after the res_valid edge: upd_valid=1, upd_pc=pc, upd_taken=res_taken. Every resolved branch produces exactly one update.
  - branch_cnt += 1, saturating at all-ones.
  - Mispredict when ptaken != res_taken. Direction only; the target is decode-computed and is not compared.
- Mispredict handling (same edge as the pop):
  - flush=1 for exactly one cycle.
  - redirect_pc = res_taken ? res_target : pc+1, with pc+1 wrapping mod 2^PC_W.
  - mispred_cnt += 1, saturating.
  - All younger entries are discarded (count=0, pointers reset to 0). Any push in that same cycle is dropped, since it is wrong-path.
  - FSM goes to FLUSH.
- FSM:
  - RUN → FLUSH on mispredict.
  - FLUSH → RUN unconditionally after 1 cycle. In FLUSH, pred_ready=0 (refill bubble).
  - res_valid in FLUSH is illegal, because the queue is empty; it sets err_underflow.
- Underflow: res_valid with count==0 sets err_underflow until reset.
  - No pop, no update, no counter change.
- Idle cycles: upd_valid and flush return to 0. upd_pc, upd_taken and redirect_pc hold their last values.

Decomposition:
- Shared package branch_pkg:
  - PC_W, opcode constants OP_BEQ=6'b000100 and OP_BNE=6'b000101.
  - typedef pc_t (logic [PC_W-1:0]).
  - typedef struct br_entry_t {pc_t pc; logic ptaken;}.
  - enum br_state_e {RUN, FLUSH}.
- One sub-module is natural: br_track_fifo, a parameterised circular FIFO of br_entry_t with push, pop and clear ports, async active-low reset, count output.
- The top level holds the FSM, compare logic, output registers and counters.

Test Plan:
- Correct prediction: push pc=0x010 ptaken=1; next cycle res_valid res_taken=1 target=0x020 → upd_valid=1, upd_pc=0x010, upd_taken=1; flush=0; branch_cnt=1, mispred_cnt=0.
- Not-taken mispredict: push 0x100 ptaken=1, push 0x104 ptaken=0; resolve first with res_taken=0 → flush=1, redirect_pc=0x101, mispred_cnt=1, count=0, pred_ready=0 for 1 cycle then 1. The 0x104 entry is never updated.
- Taken mispredict with wrap: push pc=0x3FFF ptaken=0; resolve res_taken=1 target=0x0040 → redirect_pc=0x0040. Separately, push pc=0x3FFF ptaken=1 and resolve res_taken=0 → redirect_pc=0x0000.
- Full/concurrency: push 4 entries → pred_ready=0. Pop with pred_valid high → push ignored, count=3, pred_ready=1 next cycle. Then push and pop together → count stays 3, updates come out in FIFO order.
- Mispredict plus simultaneous push: count=2, resolve oldest as mispredict while pred_valid=1 → pushed entry dropped, count=0, no later update for it.
- Underflow and reset: res_valid with empty queue → err_underflow=1, no upd_valid. Then assert rst_n=0 mid-stream with 3 entries → all outputs 0 asynchronously; after release, count=0 and pred_ready=1.
